hps_fgpa_led_sequencer: RTL and testbench
=========================================

HPS_FGPA_LED_SEQUENCER -- requirements
Module: hps_fgpa_led_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 24, width of the step-period divider.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  3  Avalon-MM word address.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-006 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data, zero wait states.
REQ-009 SHALL have port out_port  output  4  LED drive.
REQ-010 SHALL have port irq  output  1  level interrupt, high while DONE_PEND=1.

Function
REQ-011 SHALL implement the register map: 0 MANUAL[3:0]; 1 CTRL {ONESHOT[2], IRQ_EN[1], RUN[0]}; 2 LAST[1:0]; 3 PERIOD[DIV_W-1:0]; 4 STATUS (read-only); 5-7 PAT1-PAT3[3:0]; PAT0 is at address 0 shared with MANUAL.
REQ-012 SHALL accept a write when chipselect=1 and write_n=0, updating the register on that clk edge; writedata bits above register width are ignored.
REQ-013 SHALL return readdata combinationally from address, zero-extended to 32 bits; unmapped bits read 0; chipselect is not required for reads.
REQ-014 SHALL format STATUS as {DONE_PEND[4], STEP[3:2], STATE[1:0]}, with STATE encoded IDLE=0, RUN=1, DONE=2.
REQ-015 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-016 SHALL drive out_port=MANUAL in IDLE and out_port=PAT[STEP] in RUN and DONE, where PAT0=MANUAL, all registered, with no combinational path from writedata.
REQ-017 SHALL transition IDLE->RUN on the edge after RUN is written 1, with STEP=0 and tick counter=0 on RUN entry.
REQ-018 SHALL, in RUN, increment the tick counter each cycle and assert tick when counter==PERIOD, then clear the counter; PERIOD=0 gives a tick every cycle, and a step lasts PERIOD+1 cycles.
REQ-019 SHALL, on tick in RUN with STEP<LAST, increment STEP.
REQ-020 SHALL, on tick in RUN with STEP==LAST, wrap STEP to 0 when ONESHOT=0; when ONESHOT=1, hold STEP, enter DONE, and set DONE_PEND.
REQ-021 SHALL, when LAST is written below the current STEP, have the next tick treat STEP as past LAST: wrap to 0, or enter DONE if ONESHOT=1.
REQ-022 SHALL clear the tick counter on any PERIOD write and leave STEP unchanged.
REQ-023 SHALL, when RUN is written 0 in RUN or DONE, enter IDLE on the next edge, set STEP=0, and clear the counter.
REQ-024 SHALL have DONE ignore ticks and hold its output until RUN is written 0; writing RUN=1 while in DONE causes no change.
REQ-025 SHALL have DONE_PEND be sticky, cleared only by writing STATUS with bit4=1; when set and cleared in the same cycle, set wins.
REQ-026 SHALL drive irq = DONE_PEND & IRQ_EN, registered.
REQ-027 SHALL honour a simultaneous tick and CTRL write by applying the CTRL write, so RUN=0 beats a STEP advance or DONE entry.

Reset
REQ-028 SHALL, on reset_n=0 and asynchronously, clear all registers, STEP, the counter and DONE_PEND; set the FSM to IDLE; and drive out_port=0, irq=0, readdata=0 at address 0.
REQ-029 SHALL, on assertion of reset mid-RUN, abort the sequence immediately, with no resumption after release.
REQ-030 SHALL, after reset release, require an explicit RUN write before any sequencing starts.

Verification
REQ-031 SHALL cover: write MANUAL=0xA -> out_port=0xA next cycle; read address 0 = 0x0000000A.
REQ-032 SHALL cover: PAT0-3=1,2,4,8, LAST=3, PERIOD=2, RUN=1 -> out_port 1,2,4,8,1… each held 3 cycles.
REQ-033 SHALL cover: ONESHOT=1, IRQ_EN=1, LAST=1, PERIOD=0 -> out_port PAT0, PAT1, then DONE with STATUS=0x16 and irq=1; writing STATUS 0x10 drops irq.
REQ-034 SHALL cover: RUN=0 written on the same cycle as a tick at STEP==LAST in one-shot -> IDLE, DONE_PEND=0, out_port=MANUAL.
REQ-035 SHALL cover: reset_n pulsed low mid-RUN at STEP=2 -> out_port=0 and STATUS=0 without waiting for clk; after release, stays IDLE.
REQ-036 SHALL cover: LAST set to 0 while STEP=2, ONESHOT=0 -> next tick STEP=0 and sequencing continues on PAT0 only.

Source files
------------

// File: rtl/hps_fgpa_led_sequencer_if.sv
// Avalon-MM slave bus bundle for the LED sequencer.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : write strobe, active-low
//   writedata  : write data (32 bits)
//   readdata   : read data, zero wait states (32 bits)
// The master modport is the host side; the slave modport is the sequencer.
interface hps_fgpa_led_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hps_fgpa_led_sequencer.sv
// LED pattern sequencer with an Avalon-MM register interface.
// Steps out_port through PAT0..PAT[LAST] (PAT0 shares storage with MANUAL),
// each step lasting PERIOD+1 clocks, either looping or stopping once
// (one-shot) with a sticky DONE_PEND flag that can raise irq.
//   clk      : single clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port : registered LED drive
//   irq      : registered level interrupt, DONE_PEND & IRQ_EN
// Register map: 0 MANUAL/PAT0, 1 CTRL{ONESHOT,IRQ_EN,RUN}, 2 LAST,
// 3 PERIOD, 4 STATUS{DONE_PEND,STEP,STATE}, 5-7 PAT1-PAT3.
module hps_fgpa_led_sequencer #(
  parameter int unsigned DIV_W = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  hps_fgpa_led_sequencer_if.slave     bus,
  output logic [3:0]                  out_port,
  output logic                        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [3:0]         manual, manual_nx;
  logic               run, run_nx;
  logic               irq_en, irq_en_nx;
  logic               oneshot, oneshot_nx;
  logic [1:0]         last, last_nx;
  logic [DIV_W-1:0]   period, period_nx;
  logic [3:0]         pat1, pat1_nx;
  logic [3:0]         pat2, pat2_nx;
  logic [3:0]         pat3, pat3_nx;
  logic [1:0]         step, step_nx;
  logic [DIV_W-1:0]   cnt, cnt_nx;
  logic               done_pend, done_pend_nx;
  logic               set_done;
  logic               wr;
  logic               wr_period;
  logic               clr_done;
  logic [3:0]         out_nx;
  logic               irq_nx;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_period = wr && (bus.address == 3'd3);
  assign clr_done  = wr && (bus.address == 3'd4) && bus.writedata[4];

  function automatic logic [3:0] pat_sel(input logic [1:0] s,
                                         input logic [3:0] p0, input logic [3:0] p1,
                                         input logic [3:0] p2, input logic [3:0] p3);
    case (s)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return p3;
    endcase
  endfunction

  // Register-file write decode
  always_comb begin
    manual_nx  = manual;
    run_nx     = run;
    irq_en_nx  = irq_en;
    oneshot_nx = oneshot;
    last_nx    = last;
    period_nx  = period;
    pat1_nx    = pat1;
    pat2_nx    = pat2;
    pat3_nx    = pat3;
    if (wr) begin
      case (bus.address)
        3'd0: manual_nx = bus.writedata[3:0];
        3'd1: begin
          run_nx     = bus.writedata[0];
          irq_en_nx  = bus.writedata[1];
          oneshot_nx = bus.writedata[2];
        end
        3'd2: last_nx   = bus.writedata[1:0];
        3'd3: period_nx = bus.writedata[DIV_W-1:0];
        3'd5: pat1_nx   = bus.writedata[3:0];
        3'd6: pat2_nx   = bus.writedata[3:0];
        3'd7: pat3_nx   = bus.writedata[3:0];
        default: ;
      endcase
    end
  end

  // Sequencing FSM. Stopping looks at the post-write RUN value so a CTRL
  // write landing on a tick edge takes priority over the step/DONE update;
  // starting waits for the stored RUN bit, i.e. one edge after the write.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    cnt_nx   = cnt;
    set_done = 1'b0;
    case (state)
      S_IDLE: begin
        step_nx = '0;
        cnt_nx  = '0;
        if (run && run_nx) state_nx = S_RUN;
      end
      S_RUN: begin
        if (!run_nx) begin
          state_nx = S_IDLE;
          step_nx  = '0;
          cnt_nx   = '0;
        end else if (wr_period) begin
          cnt_nx = '0;
        end else if (cnt == period) begin
          cnt_nx = '0;
          if (step < last) begin
            step_nx = step + 2'd1;
          end else if (oneshot_nx) begin
            state_nx = S_DONE;
            set_done = 1'b1;
          end else begin
            step_nx = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (!run_nx) begin
          state_nx = S_IDLE;
          step_nx  = '0;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        step_nx  = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they always agree
  // with the register contents visible on the bus.
  always_comb begin
    done_pend_nx = set_done || (done_pend && !clr_done);
    irq_nx       = done_pend_nx && irq_en_nx;
    if (state_nx == S_IDLE) out_nx = manual_nx;
    else                    out_nx = pat_sel(step_nx, manual_nx, pat1_nx, pat2_nx, pat3_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      manual    <= '0;
      run       <= 1'b0;
      irq_en    <= 1'b0;
      oneshot   <= 1'b0;
      last      <= '0;
      period    <= '0;
      pat1      <= '0;
      pat2      <= '0;
      pat3      <= '0;
      step      <= '0;
      cnt       <= '0;
      done_pend <= 1'b0;
      out_port  <= '0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nx;
      manual    <= manual_nx;
      run       <= run_nx;
      irq_en    <= irq_en_nx;
      oneshot   <= oneshot_nx;
      last      <= last_nx;
      period    <= period_nx;
      pat1      <= pat1_nx;
      pat2      <= pat2_nx;
      pat3      <= pat3_nx;
      step      <= step_nx;
      cnt       <= cnt_nx;
      done_pend <= done_pend_nx;
      out_port  <= out_nx;
      irq       <= irq_nx;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0: bus.readdata[3:0]       = manual;
      3'd1: bus.readdata[2:0]       = {oneshot, irq_en, run};
      3'd2: bus.readdata[1:0]       = last;
      3'd3: bus.readdata[DIV_W-1:0] = period;
      3'd4: bus.readdata[4:0]       = {done_pend, step, state};
      3'd5: bus.readdata[3:0]       = pat1;
      3'd6: bus.readdata[3:0]       = pat2;
      3'd7: bus.readdata[3:0]       = pat3;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hps_fgpa_led_sequencer.sv
// Self-checking bench for hps_fgpa_led_sequencer: register-map vector table
// plus directed multi-cycle sequences (looping, one-shot/irq, stop on tick,
// LAST shrink, asynchronous reset mid-run).
module tb_hps_fgpa_led_sequencer;

  logic       clk;
  logic       reset_n;
  logic [3:0] out_port;
  logic       irq;

  int unsigned checks;
  int unsigned errors;

  hps_fgpa_led_sequencer_if bus_if ();

  hps_fgpa_led_sequencer #(.DIV_W(24)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  out;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] want);
    bus_if.address = a;
    #1;
    check(name, bus_if.readdata, want);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    reset_n           = 1'b0;

    vecs[0]  = '{3'd0, 32'hFFFF_FFF5, 32'h0000_0005, 4'h5};
    vecs[1]  = '{3'd1, 32'hFFFF_FFF8, 32'h0000_0000, 4'h5};
    vecs[2]  = '{3'd1, 32'h0000_0006, 32'h0000_0006, 4'h5};
    vecs[3]  = '{3'd1, 32'h0000_0000, 32'h0000_0000, 4'h5};
    vecs[4]  = '{3'd2, 32'hFFFF_FFFE, 32'h0000_0002, 4'h5};
    vecs[5]  = '{3'd3, 32'hFFFF_FFFF, 32'h00FF_FFFF, 4'h5};
    vecs[6]  = '{3'd3, 32'h1234_5678, 32'h0034_5678, 4'h5};
    vecs[7]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 4'h5};
    vecs[8]  = '{3'd5, 32'h0000_00A3, 32'h0000_0003, 4'h5};
    vecs[9]  = '{3'd6, 32'h0000_005C, 32'h0000_000C, 4'h5};
    vecs[10] = '{3'd7, 32'h0000_00F9, 32'h0000_0009, 4'h5};
    vecs[11] = '{3'd0, 32'h0000_0000, 32'h0000_0000, 4'h0};

    // Reset state
    repeat (3) step_clk();
    check("rst_out", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    read_chk("rst_rd0", 3'd0, 32'h0);
    read_chk("rst_status", 3'd4, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step_clk();

    // MANUAL write reaches the LEDs and reads back
    do_write(3'd0, 32'h0000_000A);
    check("manual_out", 32'(out_port), 32'hA);
    read_chk("manual_rd", 3'd0, 32'h0000_000A);

    // Register map table
    for (int i = 0; i < 12; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata);
      read_chk($sformatf("regmap_rd%0d", i), vecs[i].addr, vecs[i].rd);
      check($sformatf("regmap_out%0d", i), 32'(out_port), 32'(vecs[i].out));
    end

    // Write with chipselect low is ignored
    @(negedge clk);
    bus_if.address    = 3'd0;
    bus_if.writedata  = 32'hF;
    bus_if.write_n    = 1'b0;
    bus_if.chipselect = 1'b0;
    step_clk();
    bus_if.write_n = 1'b1;
    check("nocs_out", 32'(out_port), 32'h0);
    read_chk("nocs_rd", 3'd0, 32'h0);

    // Looping sequence 1,2,4,8 with 3 cycles per step
    do_write(3'd0, 32'd1);
    do_write(3'd5, 32'd2);
    do_write(3'd6, 32'd4);
    do_write(3'd7, 32'd8);
    do_write(3'd2, 32'd3);
    do_write(3'd3, 32'd2);
    do_write(3'd1, 32'd1);
    read_chk("loop_start_status", 3'd4, 32'h0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_pat;
      case ((i / 3) % 4)
        0:       exp_pat = 4'h1;
        1:       exp_pat = 4'h2;
        2:       exp_pat = 4'h4;
        default: exp_pat = 4'h8;
      endcase
      step_clk();
      check($sformatf("loop_out%0d", i), 32'(out_port), 32'(exp_pat));
    end
    do_write(3'd1, 32'd0);
    read_chk("loop_stop_status", 3'd4, 32'h0);
    check("loop_stop_out", 32'(out_port), 32'h1);

    // One-shot with interrupt
    do_write(3'd2, 32'd1);
    do_write(3'd3, 32'd0);
    do_write(3'd1, 32'd7);
    check("os_idle_out", 32'(out_port), 32'h1);
    step_clk();
    read_chk("os_s0_status", 3'd4, 32'h01);
    check("os_s0_out", 32'(out_port), 32'h1);
    step_clk();
    read_chk("os_s1_status", 3'd4, 32'h05);
    check("os_s1_out", 32'(out_port), 32'h2);
    step_clk();
    read_chk("os_done_status", 3'd4, 32'h16);
    check("os_done_out", 32'(out_port), 32'h2);
    check("os_done_irq", 32'(irq), 32'h1);
    repeat (3) step_clk();
    read_chk("os_hold_status", 3'd4, 32'h16);
    check("os_hold_out", 32'(out_port), 32'h2);
    do_write(3'd1, 32'd7);
    read_chk("os_rerun_status", 3'd4, 32'h16);
    do_write(3'd4, 32'h10);
    check("os_clr_irq", 32'(irq), 32'h0);
    read_chk("os_clr_status", 3'd4, 32'h06);
    do_write(3'd1, 32'd0);
    read_chk("os_stop_status", 3'd4, 32'h0);
    check("os_stop_out", 32'(out_port), 32'h1);

    // RUN=0 lands on the tick that would enter DONE
    do_write(3'd1, 32'd7);
    step_clk();
    step_clk();
    read_chk("race_pre_status", 3'd4, 32'h05);
    do_write(3'd1, 32'd0);
    read_chk("race_status", 3'd4, 32'h0);
    check("race_out", 32'(out_port), 32'h1);
    check("race_irq", 32'(irq), 32'h0);

    // Shrinking LAST below STEP wraps to PAT0 in loop mode
    do_write(3'd2, 32'd3);
    do_write(3'd3, 32'd3);
    do_write(3'd1, 32'd1);
    repeat (9) step_clk();
    read_chk("shrink_pre_status", 3'd4, 32'h09);
    check("shrink_pre_out", 32'(out_port), 32'h4);
    do_write(3'd2, 32'd0);
    step_clk();
    step_clk();
    check("shrink_hold_out", 32'(out_port), 32'h4);
    step_clk();
    check("shrink_wrap_out", 32'(out_port), 32'h1);
    read_chk("shrink_wrap_status", 3'd4, 32'h01);
    for (int i = 0; i < 8; i++) begin
      step_clk();
      check($sformatf("shrink_cont_out%0d", i), 32'(out_port), 32'h1);
    end
    read_chk("shrink_cont_status", 3'd4, 32'h01);
    do_write(3'd1, 32'd0);

    // Asynchronous reset mid-run at STEP=2
    do_write(3'd2, 32'd3);
    do_write(3'd3, 32'd2);
    do_write(3'd1, 32'd1);
    repeat (7) step_clk();
    read_chk("arst_pre_status", 3'd4, 32'h09);
    check("arst_pre_out", 32'(out_port), 32'h4);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out_port), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    read_chk("arst_status", 3'd4, 32'h0);
    read_chk("arst_rd0", 3'd0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step_clk();
    read_chk("arst_after_status", 3'd4, 32'h0);
    check("arst_after_out", 32'(out_port), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
